// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with stall (hold), flush (bubble) and a
// saturating bubble counter.
//   clk, rst_n         clock, asynchronous active-low reset
//   stall, flush       hazard controls; flush wins over stall
//   id_*               decoded instruction fields from ID
//   ex_*               registered copies presented to EX
//   illegal_sel        last load carried destination select 11
//   bubble_cnt         flush-inserted bubbles since reset, saturating
module id_ex_latch #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned RBITS     = 5,
  parameter int unsigned SELBITS   = 2,
  parameter int unsigned ALUOPBITS = 4,
  parameter int unsigned CNTBITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [NBITS-1:0]     id_pc_plus4,
  input  logic [NBITS-1:0]     id_rs_data,
  input  logic [NBITS-1:0]     id_rt_data,
  input  logic [NBITS-1:0]     id_imm,
  input  logic [RBITS-1:0]     id_reg_rs,
  input  logic [RBITS-1:0]     id_reg_rt,
  input  logic [RBITS-1:0]     id_reg_rd,
  input  logic [SELBITS-1:0]   id_reg_dst_sel,
  input  logic [ALUOPBITS-1:0] id_alu_op,
  input  logic                 id_alu_src,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_reg_write,
  input  logic                 id_mem_to_reg,
  output logic                 ex_valid,
  output logic [NBITS-1:0]     ex_pc_plus4,
  output logic [NBITS-1:0]     ex_rs_data,
  output logic [NBITS-1:0]     ex_rt_data,
  output logic [NBITS-1:0]     ex_imm,
  output logic [RBITS-1:0]     ex_reg_rs,
  output logic [RBITS-1:0]     ex_reg_rt,
  output logic [RBITS-1:0]     ex_reg_rd,
  output logic [SELBITS-1:0]   ex_reg_dst_sel,
  output logic [ALUOPBITS-1:0] ex_alu_op,
  output logic                 ex_alu_src,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic                 ex_mem_to_reg,
  output logic                 illegal_sel,
  output logic [CNTBITS-1:0]   bubble_cnt
);

  localparam logic [SELBITS-1:0] SEL_ILLEGAL = {SELBITS{1'b1}};
  localparam logic [CNTBITS-1:0] CNT_MAX     = {CNTBITS{1'b1}};

  logic                 valid_q,      valid_d;
  logic [NBITS-1:0]     pc_plus4_q,   pc_plus4_d;
  logic [NBITS-1:0]     rs_data_q,    rs_data_d;
  logic [NBITS-1:0]     rt_data_q,    rt_data_d;
  logic [NBITS-1:0]     imm_q,        imm_d;
  logic [RBITS-1:0]     reg_rs_q,     reg_rs_d;
  logic [RBITS-1:0]     reg_rt_q,     reg_rt_d;
  logic [RBITS-1:0]     reg_rd_q,     reg_rd_d;
  logic [SELBITS-1:0]   reg_dst_sel_q, reg_dst_sel_d;
  logic [ALUOPBITS-1:0] alu_op_q,     alu_op_d;
  logic                 alu_src_q,    alu_src_d;
  logic                 mem_read_q,   mem_read_d;
  logic                 mem_write_q,  mem_write_d;
  logic                 reg_write_q,  reg_write_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic                 illegal_q,    illegal_d;
  logic [CNTBITS-1:0]   bubble_cnt_q, bubble_cnt_d;

  logic                 sel_bad;

  // Next-state: flush loads a bubble, stall holds, otherwise load from ID.
  always_comb begin
    valid_d       = valid_q;
    pc_plus4_d    = pc_plus4_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;
    reg_rs_d      = reg_rs_q;
    reg_rt_d      = reg_rt_q;
    reg_rd_d      = reg_rd_q;
    reg_dst_sel_d = reg_dst_sel_q;
    alu_op_d      = alu_op_q;
    alu_src_d     = alu_src_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    illegal_d     = illegal_q;
    bubble_cnt_d  = bubble_cnt_q;
    sel_bad       = (id_reg_dst_sel == SEL_ILLEGAL);

    if (flush) begin
      valid_d       = 1'b0;
      pc_plus4_d    = '0;
      rs_data_d     = '0;
      rt_data_d     = '0;
      imm_d         = '0;
      reg_rs_d      = '0;
      reg_rt_d      = '0;
      reg_rd_d      = '0;
      reg_dst_sel_d = '0;
      alu_op_d      = '0;
      alu_src_d     = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      reg_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      illegal_d     = 1'b0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNTBITS'(1);
      end
    end else if (!stall) begin
      // Data and register numbers are captured even for an invalid slot;
      // only the control bits collapse to bubble values.
      valid_d       = id_valid;
      pc_plus4_d    = id_pc_plus4;
      rs_data_d     = id_rs_data;
      rt_data_d     = id_rt_data;
      imm_d         = id_imm;
      reg_rs_d      = id_reg_rs;
      reg_rt_d      = id_reg_rt;
      reg_rd_d      = id_reg_rd;
      reg_dst_sel_d = (id_valid && !sel_bad) ? id_reg_dst_sel : '0;
      alu_op_d      = id_valid ? id_alu_op : '0;
      alu_src_d     = id_valid & id_alu_src;
      mem_read_d    = id_valid & id_mem_read;
      mem_write_d   = id_valid & id_mem_write;
      // An illegal select must never reach the register file.
      reg_write_d   = id_valid & id_reg_write & ~sel_bad;
      mem_to_reg_d  = id_valid & id_mem_to_reg;
      illegal_d     = sel_bad;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      pc_plus4_q    <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      reg_rs_q      <= '0;
      reg_rt_q      <= '0;
      reg_rd_q      <= '0;
      reg_dst_sel_q <= '0;
      alu_op_q      <= '0;
      alu_src_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      illegal_q     <= 1'b0;
      bubble_cnt_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_plus4_q    <= pc_plus4_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      reg_rs_q      <= reg_rs_d;
      reg_rt_q      <= reg_rt_d;
      reg_rd_q      <= reg_rd_d;
      reg_dst_sel_q <= reg_dst_sel_d;
      alu_op_q      <= alu_op_d;
      alu_src_q     <= alu_src_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      illegal_q     <= illegal_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_pc_plus4    = pc_plus4_q;
  assign ex_rs_data     = rs_data_q;
  assign ex_rt_data     = rt_data_q;
  assign ex_imm         = imm_q;
  assign ex_reg_rs      = reg_rs_q;
  assign ex_reg_rt      = reg_rt_q;
  assign ex_reg_rd      = reg_rd_q;
  assign ex_reg_dst_sel = reg_dst_sel_q;
  assign ex_alu_op      = alu_op_q;
  assign ex_alu_src     = alu_src_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_to_reg  = mem_to_reg_q;
  assign illegal_sel    = illegal_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed bench for id_ex_latch (bubble counter narrowed to
// 4 bits so saturation is reachable), with a rule-level model compared on
// every falling edge plus literal spot checks.
module tb_id_ex_latch;

  localparam int unsigned CB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_reg_rs, id_reg_rt, id_reg_rd;
  logic [1:0]  id_reg_dst_sel;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;

  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_reg_rs, ex_reg_rt, ex_reg_rd;
  logic [1:0]  ex_reg_dst_sel;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic        illegal_sel;
  logic [CB-1:0] bubble_cnt;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  rs_n, rt_n, rd_n;
    logic [1:0]  sel;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, illegal;
    logic [CB-1:0] cnt;
  } ex_t;

  ex_t act, mdl;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  cmp_en = 1'b1;

  id_ex_latch #(.CNTBITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_reg_rs(id_reg_rs),
    .id_reg_rt(id_reg_rt), .id_reg_rd(id_reg_rd), .id_reg_dst_sel(id_reg_dst_sel),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_reg_rs(ex_reg_rs),
    .ex_reg_rt(ex_reg_rt), .ex_reg_rd(ex_reg_rd), .ex_reg_dst_sel(ex_reg_dst_sel),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .illegal_sel(illegal_sel),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = {ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_reg_rs,
           ex_reg_rt, ex_reg_rd, ex_reg_dst_sel, ex_alu_op, ex_alu_src,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           illegal_sel, bubble_cnt};
  end

  // What EX must hold after an edge, given what it held before and the ID side.
  function automatic ex_t model_next(input ex_t cur);
    ex_t n;
    if (flush) begin
      n = '0;
      n.cnt = (int'(cur.cnt) + 1 > 15) ? cur.cnt : CB'(int'(cur.cnt) + 1);
    end else if (stall) begin
      n = cur;
    end else begin
      n = '0;
      n.cnt  = cur.cnt;
      n.pc   = id_pc_plus4;  n.rs   = id_rs_data;  n.rt   = id_rt_data;
      n.imm  = id_imm;       n.rs_n = id_reg_rs;   n.rt_n = id_reg_rt;
      n.rd_n = id_reg_rd;
      n.illegal = (id_reg_dst_sel == 2'd3);
      if (id_valid) begin
        n.valid      = 1'b1;
        n.alu_op     = id_alu_op;
        n.alu_src    = id_alu_src;
        n.mem_read   = id_mem_read;
        n.mem_write  = id_mem_write;
        n.mem_to_reg = id_mem_to_reg;
        if (id_reg_dst_sel != 2'd3) begin
          n.sel       = id_reg_dst_sel;
          n.reg_write = id_reg_write;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= model_next(mdl);
  end

  // Whole-bundle comparison every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (act !== mdl) begin
        n_bad++;
        $display("FAIL model t=%0t got=%h want=%h", $time, act, mdl);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic clear_id();
    stall = 0; flush = 0; id_valid = 0;
    id_pc_plus4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_reg_rs = 0; id_reg_rt = 0; id_reg_rd = 0; id_reg_dst_sel = 0;
    id_alu_op = 0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_pc_plus4 = $urandom; id_rs_data = $urandom;
    id_rt_data = $urandom; id_imm = $urandom; id_reg_rs = 5'($urandom);
    id_reg_rt = 5'($urandom); id_reg_rd = 5'($urandom);
    id_reg_dst_sel = 2'($urandom_range(0, 3)); id_alu_op = 4'($urandom);
    id_alu_src = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    if (id_reg_dst_sel == 2'd3) id_valid = 1'b1;
  endtask

  // Advance one edge; inputs may be changed right after return.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_id();
    // Reset with noisy inputs.
    for (int i = 0; i < 3; i++) begin
      rand_id(); stall = 1'($urandom); flush = 1'($urandom);
      cyc();
    end
    chk("reset_all_zero", 64'(act == '0), 64'd1);
    clear_id();
    id_valid = 1; id_pc_plus4 = 32'h0000_0040;
    rst_n = 1'b1;
    #1;
    chk("release_before_edge", 64'(ex_valid), 64'd0);
    chk("release_pc", 64'(ex_pc_plus4), 64'd0);
    cyc();
    chk("first_edge_pc", 64'(ex_pc_plus4), 64'h40);

    // Basic load.
    clear_id();
    id_valid = 1; id_reg_rt = 5; id_reg_rd = 12; id_reg_dst_sel = 2'b10;
    id_reg_write = 1; id_rs_data = 32'hDEAD_BEEF;
    cyc();
    chk("load_rd", 64'(ex_reg_rd), 64'd12);
    chk("load_sel", 64'(ex_reg_dst_sel), 64'd2);
    chk("load_rs_data", 64'(ex_rs_data), 64'hDEAD_BEEF);
    chk("load_valid", 64'(ex_valid), 64'd1);
    chk("load_reg_write", 64'(ex_reg_write), 64'd1);

    // Stall holds instruction A while ID churns.
    clear_id();
    id_valid = 1; id_pc_plus4 = 32'h0000_0100; id_alu_op = 4'd7; id_mem_read = 1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      rand_id(); stall = 1;
      cyc();
      chk("stall_pc_hold", 64'(ex_pc_plus4), 64'h100);
      chk("stall_aluop_hold", 64'(ex_alu_op), 64'd7);
    end
    clear_id();
    id_valid = 1; id_pc_plus4 = 32'h0000_0200;
    cyc();
    chk("unstall_load_pc", 64'(ex_pc_plus4), 64'h200);

    // Flush beats stall.
    clear_id();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_pc_plus4 = 32'h300;
    stall = 1; flush = 1;
    cyc();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_reg_write", 64'(ex_reg_write), 64'd0);
    chk("flush_mem_write", 64'(ex_mem_write), 64'd0);
    chk("flush_pc_zero", 64'(ex_pc_plus4), 64'd0);
    chk("flush_cnt", 64'(bubble_cnt), 64'd1);

    // Illegal select, then a legal load writing $0 clears it.
    clear_id();
    id_valid = 1; id_reg_dst_sel = 2'b11; id_reg_write = 1; id_reg_rd = 9;
    cyc();
    chk("illegal_sel_out", 64'(ex_reg_dst_sel), 64'd0);
    chk("illegal_reg_write", 64'(ex_reg_write), 64'd0);
    chk("illegal_flag", 64'(illegal_sel), 64'd1);
    clear_id();
    id_valid = 1; id_reg_dst_sel = 2'b00; id_reg_rt = 0; id_reg_write = 1;
    cyc();
    chk("legal_clears_flag", 64'(illegal_sel), 64'd0);
    chk("dst_zero_passes", 64'(ex_reg_write), 64'd1);

    // Invalid slot: data captured, control zeroed, count unchanged.
    clear_id();
    id_valid = 0; id_pc_plus4 = 32'h44; id_alu_op = 4'd5; id_mem_read = 1;
    id_reg_write = 1; id_reg_dst_sel = 2'b10; id_reg_rd = 3;
    cyc();
    chk("inv_pc", 64'(ex_pc_plus4), 64'h44);
    chk("inv_rd", 64'(ex_reg_rd), 64'd3);
    chk("inv_mem_read", 64'(ex_mem_read), 64'd0);
    chk("inv_alu_op", 64'(ex_alu_op), 64'd0);
    chk("inv_sel", 64'(ex_reg_dst_sel), 64'd0);
    chk("inv_cnt", 64'(bubble_cnt), 64'd1);

    // Mixed traffic against the model.
    for (int i = 0; i < 24; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      cyc();
    end

    // Saturation: drive from a known count after a reset.
    clear_id();
    rst_n = 0;
    cyc();
    rst_n = 1;
    flush = 1; id_valid = 1; id_reg_write = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 3)  chk("sat_cnt_3", 64'(bubble_cnt), 64'd3);
      if (i == 15) chk("sat_cnt_15", 64'(bubble_cnt), 64'd15);
    end
    chk("sat_no_wrap", 64'(bubble_cnt), 64'd15);

    // Async reset mid-flush, between edges.
    #2 rst_n = 0;
    #1;
    chk("async_rst_cnt", 64'(bubble_cnt), 64'd0);
    chk("async_rst_all", 64'(act == '0), 64'd1);
    @(posedge clk);
    #1;
    chk("held_in_reset", 64'(bubble_cnt), 64'd0);
    rst_n = 1;
    cyc();
    chk("post_rst_flush", 64'(bubble_cnt), 64'd1);
    clear_id();
    id_valid = 1; id_pc_plus4 = 32'h500; stall = 1; flush = 0;
    cyc();
    chk("post_rst_stall", 64'(ex_pc_plus4), 64'd0);
    stall = 0;
    cyc();
    chk("post_rst_load", 64'(ex_pc_plus4), 64'h500);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
